bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with parallel load, wrap or saturate mode, terminal-count pulse and per-digit active-low seven-segment outputs. It replaces ad-hoc pairings of the binary counter and the single-digit BCD decoder for on-board displays such as scores, line counts and timers. The count register is sequential; segment outputs decode combinationally from it.

---
 rtl/bcd_updown_counter.sv | 167 ++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate ends,
// a terminal-count pulse and per-digit active-low seven-segment outputs.
// Latency: Q, tc and load_err update one clk edge after the qualifying input.
//          seg decodes combinationally from Q. No backpressure; one step per enabled edge.
//
// Ports:
//   clk, rst (sync, active-high)       clock and reset; everything updates on the rising edge
//   clear, load, en, up                control inputs; priority rst > clear > load > en
//   D [4*DIGITS-1:0]                   packed BCD load value; digit 0 in [3:0]
//   Q [4*DIGITS-1:0]                   packed BCD count; digit 0 in [3:0]
//   tc, load_err                       registered one-cycle event pulses
//   seg [7*DIGITS-1:0]                 active-low {g..a} per digit; digit i in [7i+6:7i]
//
// Optional build macro BCD_LEADING_ZERO_BLANK_EN: when defined, zero digits above
// the most significant non-zero digit are blanked. Digit 0 always displays.
module bcd_updown_counter #(
    parameter int                    DIGITS    = 4,
    parameter int                    SATURATE  = 0,
    parameter logic [4*DIGITS-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  en,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  load_err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         all_nines;
    logic         all_zero;
    logic         d_is_bcd;

    // Ripple increment/decrement across digits. At the range ends the ripple
    // naturally produces the wrapped value (9..9 -> 0..0, 0..0 -> 9..9), so
    // wrap mode simply takes inc_val/dec_val and saturate mode overrides it.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] nib;
        inc_val   = count_q;
        dec_val   = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        nib       = 4'd0;
        all_nines = 1'b1;
        all_zero  = 1'b1;
        d_is_bcd  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (nib != 4'd9) all_nines = 1'b0;
            if (nib != 4'd0) all_zero  = 1'b0;
            if (D[4*i +: 4] > 4'd9) d_is_bcd = 1'b0;
            if (carry) begin
                if (nib == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (nib == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Next-state selection; rst is handled in the flop block above all of this.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = RESET_VAL;
        end else if (load) begin
            // A rejected load still consumes the cycle: en is not honoured.
            if (d_is_bcd) count_d    = D;
            else          load_err_d = 1'b1;
        end else if (en) begin
            if (up) begin
                tc_d    = all_nines;
                count_d = (all_nines && SATURATE != 0) ? count_q : inc_val;
            end else begin
                tc_d    = all_zero;
                count_d = (all_zero && SATURATE != 0) ? count_q : dec_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= RESET_VAL;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign Q        = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

    // Q only ever holds valid BCD, so 10..15 share the blank code.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Scan from the top digit down; blank zeros until the first non-zero digit.
    always_comb begin
        logic       leading;
        logic [3:0] dig;
        seg     = '1;
        leading = 1'b1;
        dig     = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = count_q[4*i +: 4];
            if (i != 0 && leading && dig == 4'd0) begin
                seg[7*i +: 7] = 7'b1111111;
            end else begin
                seg[7*i +: 7] = seg_code(dig);
                leading = 1'b0;
            end
        end
    end
`else
    always_comb begin
        seg = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg_code(count_q[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised scoreboard bench for bcd_updown_counter: one wrap-mode and one
// saturate-mode instance share stimulus; an integer-valued reference model
// predicts Q, tc, load_err and seg, and a monitor compares each cycle.
module tb_bcd_updown_counter;

    localparam int          DIGITS = 4;
    localparam int          MAXV   = 9999;
    localparam logic [15:0] RV     = 16'h0250;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
    logic [15:0] d_in = '0;

    logic [15:0] q_w, q_s;
    logic        tc_w, tc_s, le_w, le_s;
    logic [27:0] seg_w, seg_s;

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(0), .RESET_VAL(RV)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .en(en), .up(up),
        .D(d_in), .Q(q_w), .tc(tc_w), .load_err(le_w), .seg(seg_w));

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1), .RESET_VAL(RV)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .en(en), .up(up),
        .D(d_in), .Q(q_s), .tc(tc_s), .load_err(le_s), .seg(seg_s));

    typedef struct {
        int   vw;
        logic tcw;
        logic lew;
        int   vs;
        logic tcs;
        logic les;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mv_w     = 0;
    int   mv_s     = 0;
    bit   done     = 1'b0;

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = '0;
        int          p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic bit is_bcd(input logic [15:0] b);
        for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] seg_digit(input int dig);
        case (dig)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected segments from the integer value: digit i is a leading zero
    // exactly when i > 0 and the value has fewer than i+1 decimal digits.
    function automatic logic [27:0] exp_seg(input int v);
        logic [27:0] s = '1;
        int          p = 1;
        bit          blank;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            blank = (i > 0) && (v < p);
`else
            blank = 1'b0;
`endif
            s[7*i +: 7] = blank ? 7'b1111111 : seg_digit((v / p) % 10);
            p = p * 10;
        end
        return s;
    endfunction

    function automatic void model(input bit sat, input int v,
                                  input logic r, input logic c, input logic l,
                                  input logic e, input logic u, input logic [15:0] d,
                                  output int nv, output logic ntc, output logic nle);
        nv  = v;
        ntc = 1'b0;
        nle = 1'b0;
        if (r || c) begin
            nv = bcd2int(RV);
        end else if (l) begin
            if (is_bcd(d)) nv = bcd2int(d);
            else           nle = 1'b1;
        end else if (e) begin
            if (u) begin
                if (v == MAXV) begin ntc = 1'b1; nv = sat ? v : 0; end
                else nv = v + 1;
            end else begin
                if (v == 0) begin ntc = 1'b1; nv = sat ? v : MAXV; end
                else nv = v - 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic e, input logic u, input logic [15:0] d);
        exp_t x;
        @(negedge clk);
        rst = r; clear = c; load = l; en = e; up = u; d_in = d;
        model(1'b0, mv_w, r, c, l, e, u, d, x.vw, x.tcw, x.lew);
        model(1'b1, mv_s, r, c, l, e, u, d, x.vs, x.tcs, x.les);
        mv_w = x.vw;
        mv_s = x.vs;
        sb.push_back(x);
    endtask

    // Monitor: after each rising edge, compare outputs to the oldest prediction.
    initial begin
        exp_t x;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("q_wrap",   32'(q_w),   32'(int2bcd(x.vw)));
                check("tc_wrap",  32'(tc_w),  32'(x.tcw));
                check("lerr_wrap",32'(le_w),  32'(x.lew));
                check("seg_wrap", 32'(seg_w), 32'(exp_seg(x.vw)));
                check("q_sat",    32'(q_s),   32'(int2bcd(x.vs)));
                check("tc_sat",   32'(tc_s),  32'(x.tcs));
                check("lerr_sat", 32'(le_s),  32'(x.les));
                check("seg_sat",  32'(seg_s), 32'(exp_seg(x.vs)));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        int          r;
        // reset, then count through a digit carry
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0998);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 16'h0000);
        // upper and lower ends
        drive(0, 0, 1, 0, 0, 16'h9999);
        drive(0, 0, 0, 1, 1, 16'h0000);
        drive(0, 0, 0, 1, 0, 16'h0000);
        drive(0, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h9999);
        drive(0, 0, 0, 1, 1, 16'h0000);
        drive(0, 0, 0, 1, 1, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0000);
        drive(0, 0, 0, 1, 0, 16'h0000);
        drive(0, 0, 0, 1, 0, 16'h0000);
        // rejected load with en high, then normal counting
        drive(0, 0, 1, 0, 0, 16'h0042);
        drive(0, 0, 1, 1, 1, 16'h12A4);
        drive(0, 0, 0, 1, 1, 16'h0000);
        // priority
        drive(0, 0, 1, 0, 0, 16'h0500);
        drive(1, 0, 1, 1, 1, 16'h0123);
        drive(0, 0, 1, 0, 0, 16'h0500);
        drive(0, 1, 1, 0, 0, 16'h0777);
        drive(0, 0, 1, 1, 1, 16'h0007);
        // segment patterns including leading zeros
        drive(0, 0, 1, 0, 0, 16'h0040);
        drive(0, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0000);
        drive(0, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h8765);
        // randomised traffic
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            d = '0;
            if ($urandom_range(0, 99) < 70) begin
                for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
            end else if ($urandom_range(0, 1) == 1) begin
                d = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            end else begin
                d = 16'($urandom);
            end
            if (r < 2)       drive(1, 0, 0, 1'($urandom), 1'($urandom), d);
            else if (r < 5)  drive(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), d);
            else if (r < 17) drive(0, 0, 1, 1'($urandom), 1'($urandom), d);
            else             drive(0, 0, 0, ($urandom_range(0, 9) < 8), 1'($urandom), d);
        end
        drive(0, 0, 0, 0, 0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
